// File: rtl/hit_tone_player.sv
// Square-wave hit tone generator: a rising edge on play_sound starts a fixed-length
// tone whose pitch follows the difficulty level, streamed into the codec write port.
module hit_tone_player #(
    parameter int                 SAMPLE_COUNT     = 4800,
    parameter int                 HALF_PERIOD_BASE = 48,
    parameter logic signed [31:0] AMPLITUDE        = 32'sh0100_0000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        play_sound,
    input  logic [1:0]  difficulty_level,
    input  logic        audio_out_allowed,
    output logic        write_audio_out,
    output logic [31:0] left_channel_audio_out,
    output logic [31:0] right_channel_audio_out,
    output logic        busy,
    output logic        done
);

    typedef enum logic {IDLE, PLAY} state_t;

    localparam logic [15:0] LAST_IDX  = 16'(SAMPLE_COUNT - 1);
    localparam logic [15:0] HALF_BASE = 16'(HALF_PERIOD_BASE);
    localparam logic [31:0] POS_VAL   = AMPLITUDE;
    localparam logic [31:0] NEG_VAL   = -AMPLITUDE;

    state_t      state_q, state_d;
    logic        play_q, play_d;
    logic [15:0] idx_q, idx_d;
    logic [15:0] phase_q, phase_d;
    logic        pol_q, pol_d;
    logic [15:0] half_q, half_d;
    logic [31:0] sample_q, sample_d;
    logic        done_q, done_d;

    logic        trig;
    logic        accept;
    logic [15:0] half_sel;

    assign trig   = play_sound & ~play_q;
    assign accept = (state_q == PLAY) & audio_out_allowed;

    always_comb begin
        half_sel = HALF_BASE;
        case (difficulty_level)
            2'd2:    half_sel = HALF_BASE >> 1;
            2'd3:    half_sel = HALF_BASE >> 2;
            default: half_sel = HALF_BASE;
        endcase
        if (half_sel == 16'd0) begin
            half_sel = 16'd1;
        end
    end

    always_comb begin
        state_d  = state_q;
        play_d   = play_sound;
        idx_d    = idx_q;
        phase_d  = phase_q;
        pol_d    = pol_q;
        half_d   = half_q;
        sample_d = sample_q;
        done_d   = 1'b0;

        // A trigger always wins, even over the final accept of a running tone.
        if (trig) begin
            state_d  = PLAY;
            idx_d    = 16'd0;
            phase_d  = 16'd0;
            pol_d    = 1'b1;
            half_d   = half_sel;
            sample_d = POS_VAL;
        end else if (accept) begin
            if (idx_q == LAST_IDX) begin
                state_d  = IDLE;
                done_d   = 1'b1;
                sample_d = 32'd0;
                idx_d    = 16'd0;
                phase_d  = 16'd0;
                pol_d    = 1'b1;
            end else begin
                idx_d = idx_q + 16'd1;
                if (phase_q == half_q - 16'd1) begin
                    phase_d  = 16'd0;
                    pol_d    = ~pol_q;
                    sample_d = pol_q ? NEG_VAL : POS_VAL;
                end else begin
                    phase_d = phase_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            play_q   <= 1'b0;
            idx_q    <= 16'd0;
            phase_q  <= 16'd0;
            pol_q    <= 1'b1;
            half_q   <= HALF_BASE;
            sample_q <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            play_q   <= play_d;
            idx_q    <= idx_d;
            phase_q  <= phase_d;
            pol_q    <= pol_d;
            half_q   <= half_d;
            sample_q <= sample_d;
            done_q   <= done_d;
        end
    end

    assign busy                    = (state_q == PLAY);
    assign write_audio_out         = accept;
    assign left_channel_audio_out  = sample_q;
    assign right_channel_audio_out = sample_q;
    assign done                    = done_q;

endmodule

// File: tb/tb_hit_tone_player.sv
// Randomized self-checking bench for hit_tone_player against a sample-count based tone model.
module tb_hit_tone_player;

    localparam int SC   = 8;
    localparam int HB   = 4;
    localparam int AMP  = 100;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        play_sound;
    logic [1:0]  difficulty_level;
    logic        audio_out_allowed;
    logic        write_audio_out;
    logic [31:0] left_channel_audio_out;
    logic [31:0] right_channel_audio_out;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    // Reference model: a tone is just "how many samples accepted so far" plus the pitch.
    bit m_busy      = 1'b0;
    bit m_prev_play = 1'b0;
    bit m_done_now  = 1'b0;
    int m_count     = 0;
    int m_half      = HB;

    int xfer_seen = 0;
    int done_seen = 0;

    hit_tone_player #(
        .SAMPLE_COUNT    (SC),
        .HALF_PERIOD_BASE(HB),
        .AMPLITUDE       (32'sd100)
    ) dut (
        .CLOCK_50               (CLOCK_50),
        .reset                  (reset),
        .play_sound             (play_sound),
        .difficulty_level       (difficulty_level),
        .audio_out_allowed      (audio_out_allowed),
        .write_audio_out        (write_audio_out),
        .left_channel_audio_out (left_channel_audio_out),
        .right_channel_audio_out(right_channel_audio_out),
        .busy                   (busy),
        .done                   (done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic int half_for(input logic [1:0] d);
        int h;
        case (d)
            2'd2:    h = HB / 2;
            2'd3:    h = HB / 4;
            default: h = HB;
        endcase
        if (h == 0) h = 1;
        return h;
    endfunction

    function automatic logic [31:0] expected_sample();
        int v;
        if (!m_busy) return 32'd0;
        v = (((m_count / m_half) % 2) == 0) ? AMP : -AMP;
        return 32'(v);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at %0t",
                     tag, $signed(got), got, $signed(exp), exp, $time);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check, then advance the model.
    task automatic applyStimulus(input logic p, input logic [1:0] d, input logic a);
        bit trig;
        play_sound        = p;
        difficulty_level  = d;
        audio_out_allowed = a;
        #1;
        checkOutput("busy",  32'(busy),            32'(m_busy));
        checkOutput("write", 32'(write_audio_out), 32'(m_busy & a));
        checkOutput("left",  left_channel_audio_out,  expected_sample());
        checkOutput("right", right_channel_audio_out, expected_sample());
        checkOutput("done",  32'(done),            32'(m_done_now));
        if (write_audio_out && audio_out_allowed) xfer_seen++;
        if (done) done_seen++;

        trig        = p && !m_prev_play;
        m_prev_play = p;
        m_done_now  = 1'b0;
        if (trig) begin
            m_busy  = 1'b1;
            m_count = 0;
            m_half  = half_for(d);
        end else if (m_busy && a) begin
            m_count++;
            if (m_count == SC) begin
                m_busy     = 1'b0;
                m_done_now = 1'b1;
                m_count    = 0;
            end
        end
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
    endtask

    task automatic checkTally(input string tag, input int exp_xfer, input int exp_done);
        checkOutput({tag, "_xfers"}, 32'(xfer_seen), 32'(exp_xfer));
        checkOutput({tag, "_dones"}, 32'(done_seen), 32'(exp_done));
        xfer_seen = 0;
        done_seen = 0;
    endtask

    task automatic playTone(input logic [1:0] d);
        applyStimulus(1'b1, d, 1'b1);
        for (int i = 0; i < SC + 2; i++) applyStimulus(1'b0, d, 1'b1);
    endtask

    initial begin
        logic [1:0] pitches [3];
        int guard;
        pitches[0] = 2'd3;
        pitches[1] = 2'd2;
        pitches[2] = 2'd0;

        reset             = 1'b1;
        play_sound        = 1'b0;
        difficulty_level  = 2'd1;
        audio_out_allowed = 1'b0;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        #1;
        checkOutput("rst_busy",  32'(busy), 32'd0);
        checkOutput("rst_write", 32'(write_audio_out), 32'd0);
        checkOutput("rst_left",  left_channel_audio_out, 32'd0);
        checkOutput("rst_done",  32'(done), 32'd0);
        @(negedge CLOCK_50);
        reset = 1'b0;

        // Basic tone, then the other pitches.
        playTone(2'd1);
        checkTally("basic", SC, 1);
        foreach (pitches[k]) begin
            playTone(pitches[k]);
            checkTally("pitch", SC, 1);
        end

        // Backpressure with a biased random allowed.
        applyStimulus(1'b1, 2'd1, 1'b0);
        guard = 0;
        while (m_busy && guard < 300) begin
            applyStimulus(1'b0, 2'd1, ($urandom_range(0, 2) != 0));
            guard++;
        end
        applyStimulus(1'b0, 2'd1, 1'b1);
        applyStimulus(1'b0, 2'd1, 1'b0);
        checkTally("backpressure", SC, 1);

        // Level held high triggers once; a fresh edge triggers again.
        for (int i = 0; i < 50; i++) applyStimulus(1'b1, 2'd1, 1'b1);
        for (int i = 0; i < 5; i++)  applyStimulus(1'b0, 2'd1, 1'b1);
        for (int i = 0; i < 14; i++) applyStimulus(1'b1, 2'd1, 1'b1);
        applyStimulus(1'b0, 2'd1, 1'b1);
        checkTally("level_hold", 2 * SC, 2);

        // Retrigger after five accepts with a pitch change.
        applyStimulus(1'b1, 2'd1, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 2'd1, 1'b1);
        applyStimulus(1'b1, 2'd3, 1'b1);
        for (int i = 0; i < SC + 2; i++) applyStimulus(1'b0, 2'd3, 1'b1);
        checkTally("retrig_mid", 5 + 1 + SC, 1);

        // Retrigger coinciding with the final accept.
        applyStimulus(1'b1, 2'd1, 1'b1);
        for (int i = 0; i < SC - 1; i++) applyStimulus(1'b0, 2'd1, 1'b1);
        applyStimulus(1'b1, 2'd2, 1'b1);
        for (int i = 0; i < SC + 2; i++) applyStimulus(1'b0, 2'd2, 1'b1);
        checkTally("retrig_last", 2 * SC, 1);

        // Asynchronous reset mid-tone.
        applyStimulus(1'b1, 2'd1, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'd1, 1'b1);
        reset = 1'b1;
        #1;
        checkOutput("async_busy",  32'(busy), 32'd0);
        checkOutput("async_write", 32'(write_audio_out), 32'd0);
        checkOutput("async_left",  left_channel_audio_out, 32'd0);
        checkOutput("async_right", right_channel_audio_out, 32'd0);
        checkOutput("async_done",  32'(done), 32'd0);
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        #1;
        checkOutput("held_done", 32'(done), 32'd0);
        @(negedge CLOCK_50);
        reset       = 1'b0;
        m_busy      = 1'b0;
        m_prev_play = 1'b0;
        m_done_now  = 1'b0;
        m_count     = 0;
        checkTally("reset_mid", 3, 0);
        playTone(2'd1);
        checkTally("after_reset", SC, 1);

        // Free-running random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 9) == 0), 2'($urandom_range(0, 3)),
                          ($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
